// File: rtl/dmem_access_unit_pkg.sv
// Shared types and lane helpers for the data-memory access path.
// Access sizes, FSM states, alignment check, byte enables and store lane replication.
package core_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } dsize_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10,
        DONE = 2'b11
    } dmem_state_t;

    // Reserved size is reported through the same fault path as misalignment
    function automatic logic is_misaligned(input dsize_t size, input logic [1:0] offset);
        logic bad;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input dsize_t size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_BYTE: be = 4'b0001 << offset;
            SIZE_HALF: be = 4'b0011 << {offset[1], 1'b0};
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input dsize_t size, input logic [31:0] wdata);
        logic [31:0] lanes;
        case (size)
            SIZE_BYTE: lanes = {4{wdata[7:0]}};
            SIZE_HALF: lanes = {2{wdata[15:0]}};
            default:   lanes = wdata;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_extend.sv
// Load-data alignment: shifts the aligned bus word down to the accessed lane
// and sign- or zero-extends byte and half results.
module dmem_load_extend
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  dsize_t          size,
    input  logic            zero_ext,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        result = shifted;
        case (size)
            SIZE_BYTE: result = zero_ext ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                         : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            SIZE_HALF: result = zero_ext ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                         : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            default:   result = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store engine: drives a req/gnt/rvalid data bus, stalls the
// pipeline until the access completes and returns extended load data.
module dmem_access_unit
    import core_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [1:0]      i_d_size,
    input  logic            i_d_unsigned,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_stall,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_rdata_valid,
    output logic            o_access_fault,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata
);

    dmem_state_t     state_q, state_d;
    dsize_t          size_in, size_q;
    logic            access, fault, start;
    logic            we_q, zero_ext_q, req_q, rdata_valid_q;
    logic [1:0]      offset_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q, ext_data;

    assign size_in = dsize_t'(i_d_size);
    assign access  = i_valid & (i_mem_read | i_mem_write);
    assign fault   = access & ((i_mem_read & i_mem_write) | is_misaligned(size_in, i_addr[1:0]));
    assign start   = access & ~fault;

    always_comb begin
        state_d        = state_q;
        o_stall        = 1'b0;
        o_access_fault = 1'b0;
        case (state_q)
            IDLE: begin
                o_access_fault = fault;
                if (start) begin
                    o_stall = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                o_stall = 1'b1;
                if (i_dmem_gnt) state_d = we_q ? DONE : WAIT;
            end
            WAIT: begin
                o_stall = 1'b1;
                if (i_dmem_rvalid) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req and rdata_valid are registered from the next state so they line up with REQ/DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            req_q         <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= '0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            be_q          <= '0;
            wdata_q       <= '0;
            size_q        <= SIZE_BYTE;
            zero_ext_q    <= 1'b0;
            offset_q      <= '0;
        end else begin
            state_q       <= state_d;
            req_q         <= (state_d == REQ);
            rdata_valid_q <= (state_d == DONE) && !we_q;
            if (state_q == IDLE && start) begin
                we_q       <= i_mem_write;
                addr_q     <= {i_addr[XLEN-1:2], 2'b00};
                be_q       <= byte_enables(size_in, i_addr[1:0]);
                wdata_q    <= store_lanes(size_in, i_wdata);
                size_q     <= size_in;
                zero_ext_q <= i_d_unsigned;
                offset_q   <= i_addr[1:0];
            end
            if (state_q == WAIT && i_dmem_rvalid) rdata_q <= ext_data;
        end
    end

    dmem_load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata    (i_dmem_rdata),
        .offset   (offset_q),
        .size     (size_q),
        .zero_ext (zero_ext_q),
        .result   (ext_data)
    );

    assign o_dmem_req    = req_q;
    assign o_dmem_we     = we_q;
    assign o_dmem_addr   = addr_q;
    assign o_dmem_be     = be_q;
    assign o_dmem_wdata  = wdata_q;
    assign o_rdata       = rdata_q;
    assign o_rdata_valid = rdata_valid_q;

endmodule
